// File: rtl/rv_int_ctrl.sv
// Small RISC-V style interrupt controller: 8 synchronized device lines plus an
// optional machine timer (define RV_INT_CTRL_TIMER_EN), fixed-priority arbitration
// and an IDLE/REQ/SERVICE handshake with the core.
module rv_int_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  irq_src,
    input  logic        int_claim,
    input  logic        int_complete,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    output logic        INT,
    output logic [3:0]  int_id,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVICE
    } state_t;

    localparam logic [2:0] A_ENABLE   = 3'd0;
    localparam logic [2:0] A_EDGE     = 3'd1;
    localparam logic [2:0] A_PENDING  = 3'd2;
    localparam logic [2:0] A_CLAIMED  = 3'd3;
    localparam logic [2:0] A_MTIME    = 3'd4;
    localparam logic [2:0] A_MTIMECMP = 3'd5;

    logic [7:0] r_sync1, r_sync2, r_sync_prev;
    logic [8:0] r_enable;
    logic [7:0] r_edge;
    logic [7:0] r_pend;
    logic [3:0] r_claimed;
    state_t     r_state;
    logic       r_int;
    logic [3:0] r_int_id;
    logic       r_busy;

    state_t     w_state_next;
    logic       w_int_next;
    logic [3:0] w_id_next;
    logic [3:0] w_claimed_next;
    logic       w_busy_next;
    logic       w_claim_take;

    logic       w_wr_enable, w_wr_edge, w_wr_pend;
    logic [7:0] w_rise, w_w1c, w_claim_clr, w_pend_next;
    logic [8:0] w_lvl_mask, w_arb;
    logic [3:0] w_win_id;
    logic       w_timer_pend;
    logic [8:0] w_enable_wdata;

    assign w_wr_enable = cfg_we && (cfg_addr == A_ENABLE);
    assign w_wr_edge   = cfg_we && (cfg_addr == A_EDGE);
    assign w_wr_pend   = cfg_we && (cfg_addr == A_PENDING);

`ifdef RV_INT_CTRL_TIMER_EN
    logic [31:0] r_mtime, r_mtimecmp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtime    <= 32'd0;
            r_mtimecmp <= 32'hFFFF_FFFF;
        end else begin
            // A software write to MTIME wins over the free-running increment.
            if (cfg_we && (cfg_addr == A_MTIME)) r_mtime <= cfg_wdata;
            else                                 r_mtime <= r_mtime + 32'd1;
            if (cfg_we && (cfg_addr == A_MTIMECMP)) r_mtimecmp <= cfg_wdata;
        end
    end

    assign w_timer_pend   = (r_mtime >= r_mtimecmp);
    assign w_enable_wdata = cfg_wdata[8:0];
`else
    logic w_unused_wdata;
    assign w_unused_wdata = ^cfg_wdata[31:8];
    assign w_timer_pend   = 1'b0;
    assign w_enable_wdata = {1'b0, cfg_wdata[7:0]};
`endif

    // Pending update: edge bits latch rises (set beats clear), level bits track the line.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_claim_clr = 8'd0;
        w_lvl_mask  = 9'd0;
        for (int k = 0; k < 8; k++) begin
            if (w_claim_take && (r_int_id == 4'(k + 1))) w_claim_clr[k] = 1'b1;
            if (r_claimed == 4'(k + 1))                  w_lvl_mask[k]  = ~r_edge[k];
        end
        w_lvl_mask[8] = (r_claimed == 4'd9);
        w_rise        = r_sync2 & ~r_sync_prev;
        w_w1c         = (w_wr_pend ? cfg_wdata[7:0] : 8'd0) & r_edge;
        w_pend_next   = (r_edge & ((r_pend & ~(w_w1c | (w_claim_clr & r_edge))) | w_rise))
                      | (~r_edge & r_sync2);
    end

    assign w_arb = {w_timer_pend, r_pend} & r_enable & ~w_lvl_mask;

    always_comb begin
        w_win_id = 4'd0;
        for (int k = 8; k >= 0; k--) begin
            if (w_arb[k]) w_win_id = 4'(k + 1);
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_int_next     = r_int;
        w_id_next      = r_int_id;
        w_claimed_next = r_claimed;
        w_busy_next    = r_busy;
        w_claim_take   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_arb) begin
                    w_state_next = S_REQ;
                    w_int_next   = 1'b1;
                    w_id_next    = w_win_id;
                end else begin
                    w_int_next   = 1'b0;
                    w_id_next    = 4'd0;
                end
            end
            S_REQ: begin
                if (int_claim) begin
                    w_state_next   = S_SERVICE;
                    w_claimed_next = r_int_id;
                    w_int_next     = 1'b0;
                    w_busy_next    = 1'b1;
                    w_claim_take   = 1'b1;
                end else if (!(|w_arb)) begin
                    w_state_next   = S_IDLE;
                    w_int_next     = 1'b0;
                    w_id_next      = 4'd0;
                end else begin
                    w_id_next      = w_win_id;
                end
            end
            S_SERVICE: begin
                // A claim arriving with the complete is dropped; no nesting.
                if (int_complete) begin
                    w_state_next   = S_IDLE;
                    w_claimed_next = 4'd0;
                    w_busy_next    = 1'b0;
                    w_id_next      = 4'd0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_int_next   = 1'b0;
                w_id_next    = 4'd0;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 8'd0;
            r_sync2     <= 8'd0;
            r_sync_prev <= 8'd0;
            r_enable    <= 9'd0;
            r_edge      <= 8'd0;
            r_pend      <= 8'd0;
            r_claimed   <= 4'd0;
            r_state     <= S_IDLE;
            r_int       <= 1'b0;
            r_int_id    <= 4'd0;
            r_busy      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_sync1     <= irq_src;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
            if (w_wr_enable) r_enable <= w_enable_wdata;
            if (w_wr_edge)   r_edge   <= cfg_wdata[7:0];
            r_pend      <= w_pend_next;
            r_claimed   <= w_claimed_next;
            r_state     <= w_state_next;
            r_int       <= w_int_next;
            r_int_id    <= w_id_next;
            r_busy      <= w_busy_next;
        end
    end

    always_comb begin
        cfg_rdata = 32'd0;
        case (cfg_addr)
            A_ENABLE:   cfg_rdata = {23'd0, r_enable};
            A_EDGE:     cfg_rdata = {24'd0, r_edge};
            A_PENDING:  cfg_rdata = {23'd0, w_timer_pend, r_pend};
            A_CLAIMED:  cfg_rdata = {28'd0, r_claimed};
`ifdef RV_INT_CTRL_TIMER_EN
            A_MTIME:    cfg_rdata = r_mtime;
            A_MTIMECMP: cfg_rdata = r_mtimecmp;
`endif
            default:    cfg_rdata = 32'd0;
        endcase
    end

    assign INT    = r_int;
    assign int_id = r_int_id;
    assign busy   = r_busy;

endmodule

// File: tb/tb_rv_int_ctrl.sv
// Directed self-checking bench for rv_int_ctrl; timer scenario is selected by
// RV_INT_CTRL_TIMER_EN to match the build of the design.
module tb_rv_int_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  irq_src = 8'd0;
    logic        int_claim = 1'b0;
    logic        int_complete = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = 3'd0;
    logic [31:0] cfg_wdata = 32'd0;
    logic [31:0] cfg_rdata;
    logic        INT;
    logic [3:0]  int_id;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef RV_INT_CTRL_TIMER_EN
    localparam logic [31:0] EXP_CMP_RST = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] EXP_CMP_RST = 32'd0;
`endif

    rv_int_ctrl dut (
        .clk(clk), .rst(rst), .irq_src(irq_src),
        .int_claim(int_claim), .int_complete(int_complete),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .INT(INT), .int_id(int_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick(1);
        cfg_we = 1'b0; cfg_wdata = 32'd0;
    endtask

    task automatic cfg_read(input logic [2:0] a, output logic [31:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic pulse(input logic claim, input logic complete);
        int_claim = claim; int_complete = complete;
        tick(1);
        int_claim = 1'b0; int_complete = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        tick(2);
        checks++; if ({INT, int_id, busy} !== 6'd0) begin errors++; $display("FAIL reset_outputs: INT=%b id=%0d busy=%b expected 0/0/0", INT, int_id, busy); end
        cfg_read(3'd0, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_enable: got %h expected 0", d); end
        cfg_read(3'd2, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_pending: got %h expected 0", d); end
        cfg_read(3'd5, d); checks++; if (d !== EXP_CMP_RST) begin errors++; $display("FAIL reset_mtimecmp: got %h expected %h", d, EXP_CMP_RST); end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_edge_latency();
        logic [31:0] d;
        cfg_write(3'd0, 32'h001);
        cfg_write(3'd1, 32'h01);
        tick(2);
        irq_src = 8'h01;
        tick(1);
        irq_src = 8'h00;
        tick(2);
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL edge_early: INT=%b expected 0 after 3 edges", INT); end
        tick(1);
        checks++; if (INT !== 1'b1 || int_id !== 4'd1) begin errors++; $display("FAIL edge_latency: INT=%b id=%0d expected 1/1", INT, int_id); end
        pulse(1'b1, 1'b0);
        checks++; if (INT !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL edge_claim: INT=%b busy=%b expected 0/1", INT, busy); end
        cfg_read(3'd3, d); checks++; if (d !== 32'd1) begin errors++; $display("FAIL edge_claimed: got %0d expected 1", d); end
        cfg_read(3'd2, d); checks++; if (d[0] !== 1'b0) begin errors++; $display("FAIL edge_pend_clr: got %b expected 0", d[0]); end
        pulse(1'b0, 1'b1);
        cfg_read(3'd3, d);
        checks++; if (busy !== 1'b0 || d !== 32'd0) begin errors++; $display("FAIL edge_complete: busy=%b claimed=%0d expected 0/0", busy, d); end
        tick(2);
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL edge_no_rearm: INT=%b expected 0", INT); end
    endtask

    task automatic test_w1c();
        logic [31:0] d;
        cfg_write(3'd0, 32'h000);
        cfg_write(3'd1, 32'h04);
        irq_src = 8'h04; tick(1); irq_src = 8'h00; tick(2);
        cfg_read(3'd2, d); checks++; if (d !== 32'h04 || INT !== 1'b0) begin errors++; $display("FAIL w1c_set: pend=%h INT=%b expected 04/0", d, INT); end
        cfg_write(3'd2, 32'h04);
        cfg_read(3'd2, d); checks++; if (d !== 32'h00) begin errors++; $display("FAIL w1c_clear: pend=%h expected 00", d); end
        // Rise detected on the same edge as the W1C write: set must win.
        irq_src = 8'h04; tick(1); irq_src = 8'h00; tick(1);
        cfg_write(3'd2, 32'h04);
        cfg_read(3'd2, d); checks++; if (d !== 32'h04) begin errors++; $display("FAIL w1c_set_wins: pend=%h expected 04", d); end
        cfg_write(3'd2, 32'h04);
    endtask

    task automatic test_level_priority();
        logic [31:0] d;
        cfg_write(3'd1, 32'h00);
        cfg_write(3'd0, 32'h0FF);
        irq_src = 8'h20;
        tick(4);
        checks++; if (INT !== 1'b1 || int_id !== 4'd6) begin errors++; $display("FAIL level_first: INT=%b id=%0d expected 1/6", INT, int_id); end
        irq_src = 8'h24;
        tick(3);
        checks++; if (int_id !== 4'd6) begin errors++; $display("FAIL level_hold: id=%0d expected 6", int_id); end
        tick(1);
        checks++; if (INT !== 1'b1 || int_id !== 4'd3) begin errors++; $display("FAIL level_preempt: INT=%b id=%0d expected 1/3", INT, int_id); end
        pulse(1'b1, 1'b0);
        cfg_read(3'd3, d); checks++; if (d !== 32'd3 || INT !== 1'b0) begin errors++; $display("FAIL level_claim: claimed=%0d INT=%b expected 3/0", d, INT); end
        tick(3);
        checks++; if (INT !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL level_no_nest: INT=%b busy=%b expected 0/1", INT, busy); end
        pulse(1'b0, 1'b1);
        checks++; if (INT !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL level_complete: INT=%b busy=%b expected 0/0", INT, busy); end
        tick(1);
        checks++; if (INT !== 1'b1 || int_id !== 4'd3) begin errors++; $display("FAIL level_rearm: INT=%b id=%0d expected 1/3", INT, int_id); end
        irq_src = 8'h00;
        tick(3);
        checks++; if (INT !== 1'b1) begin errors++; $display("FAIL level_drop_early: INT=%b expected 1", INT); end
        tick(1);
        checks++; if (INT !== 1'b0 || int_id !== 4'd0) begin errors++; $display("FAIL level_vanish: INT=%b id=%0d expected 0/0", INT, int_id); end
    endtask

    task automatic test_claim_complete();
        logic [31:0] d;
        cfg_write(3'd0, 32'h002);
        cfg_write(3'd1, 32'h02);
        pulse(1'b1, 1'b0);
        cfg_read(3'd3, d);
        checks++; if (busy !== 1'b0 || INT !== 1'b0 || d !== 32'd0) begin errors++; $display("FAIL claim_in_idle: busy=%b INT=%b claimed=%0d expected 0/0/0", busy, INT, d); end
        irq_src = 8'h02; tick(1); irq_src = 8'h00; tick(3);
        checks++; if (INT !== 1'b1 || int_id !== 4'd2) begin errors++; $display("FAIL cc_req: INT=%b id=%0d expected 1/2", INT, int_id); end
        pulse(1'b0, 1'b1);
        checks++; if (INT !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL complete_in_req: INT=%b busy=%b expected 1/0", INT, busy); end
        pulse(1'b1, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cc_claim: busy=%b expected 1", busy); end
        pulse(1'b1, 1'b1);
        cfg_read(3'd3, d);
        checks++; if (busy !== 1'b0 || d !== 32'd0 || INT !== 1'b0) begin errors++; $display("FAIL cc_together: busy=%b claimed=%0d INT=%b expected 0/0/0", busy, d, INT); end
    endtask

    task automatic test_enable_and_reset();
        logic [31:0] d;
        cfg_write(3'd1, 32'h00);
        cfg_write(3'd0, 32'h008);
        irq_src = 8'h08;
        tick(4);
        checks++; if (INT !== 1'b1 || int_id !== 4'd4) begin errors++; $display("FAIL en_req: INT=%b id=%0d expected 1/4", INT, int_id); end
        cfg_write(3'd0, 32'h000);
        checks++; if (INT !== 1'b1) begin errors++; $display("FAIL en_clear_same: INT=%b expected 1", INT); end
        tick(1);
        checks++; if (INT !== 1'b0 || int_id !== 4'd0) begin errors++; $display("FAIL en_clear_next: INT=%b id=%0d expected 0/0", INT, int_id); end
        cfg_write(3'd0, 32'h008);
        tick(1);
        pulse(1'b1, 1'b0);
        cfg_write(3'd0, 32'h000);
        cfg_read(3'd3, d);
        checks++; if (d !== 32'd4 || busy !== 1'b1) begin errors++; $display("FAIL en_claimed_kept: claimed=%0d busy=%b expected 4/1", d, busy); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        irq_src = 8'h00;
        checks++; if ({INT, int_id, busy} !== 6'd0) begin errors++; $display("FAIL rst_service_out: INT=%b id=%0d busy=%b expected 0/0/0", INT, int_id, busy); end
        cfg_read(3'd3, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_service_claimed: got %0d expected 0", d); end
        cfg_read(3'd0, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_service_enable: got %h expected 0", d); end
        tick(3);
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        cfg_write(3'd6, 32'hDEAD_BEEF);
        cfg_read(3'd6, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL addr6: got %h expected 0", d); end
        cfg_read(3'd7, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL addr7: got %h expected 0", d); end
    endtask

`ifdef RV_INT_CTRL_TIMER_EN
    task automatic test_timer();
        logic [31:0] d;
        int          n;
        rst = 1'b1; tick(1); rst = 1'b0;
        cfg_write(3'd0, 32'h100);
        cfg_write(3'd5, 32'd20);
        n = 0;
        while (INT !== 1'b1 && n < 60) begin tick(1); n++; end
        checks++; if (INT !== 1'b1 || int_id !== 4'd9) begin errors++; $display("FAIL timer_req: INT=%b id=%0d expected 1/9", INT, int_id); end
        cfg_read(3'd4, d); checks++; if (d < 32'd20) begin errors++; $display("FAIL timer_mtime: got %0d expected >=20", d); end
        cfg_write(3'd5, 32'hFFFF_FFFF);
        cfg_read(3'd2, d); checks++; if (d[8] !== 1'b0) begin errors++; $display("FAIL timer_pend_clr: got %b expected 0", d[8]); end
        tick(1);
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL timer_int_clr: INT=%b expected 0", INT); end
        cfg_write(3'd4, 32'd100);
        cfg_read(3'd4, d); checks++; if (d !== 32'd100) begin errors++; $display("FAIL mtime_write: got %0d expected 100", d); end
        tick(1);
        cfg_read(3'd4, d); checks++; if (d !== 32'd101) begin errors++; $display("FAIL mtime_inc: got %0d expected 101", d); end
        cfg_write(3'd4, 32'hFFFF_FFFF);
        tick(1);
        cfg_read(3'd4, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL mtime_wrap: got %h expected 0", d); end
    endtask
`else
    task automatic test_timer();
        logic [31:0] d;
        cfg_write(3'd0, 32'h1FF);
        cfg_read(3'd0, d); checks++; if (d !== 32'h0FF) begin errors++; $display("FAIL notimer_enable8: got %h expected 0ff", d); end
        cfg_write(3'd5, 32'd20);
        cfg_read(3'd5, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL notimer_cmp: got %h expected 0", d); end
        cfg_read(3'd4, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL notimer_mtime: got %h expected 0", d); end
        tick(3);
        cfg_read(3'd2, d);
        checks++; if (d[8] !== 1'b0 || INT !== 1'b0) begin errors++; $display("FAIL notimer_pend: pend8=%b INT=%b expected 0/0", d[8], INT); end
    endtask
`endif

    initial begin
        test_reset();
        test_edge_latency();
        test_w1c();
        test_level_priority();
        test_claim_complete();
        test_enable_and_reset();
        test_unmapped();
        test_timer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_int_ctrl.md
RV_INT_CTRL -- requirements
Module: rv_int_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: irq_src  input  8  asynchronous device interrupt lines; bit k is source id k+1.
REQ-004 SHALL have port: int_claim  input  1  one-cycle pulse from core trap entry (trap taken).
REQ-005 SHALL have port: int_complete  input  1  one-cycle pulse from core MRET.
REQ-006 SHALL have port: cfg_we  input  1  config write strobe.
REQ-007 SHALL have port: cfg_addr  input  3  config register index.
REQ-008 SHALL have port: cfg_wdata  input  32  config write data.
REQ-009 SHALL have port: cfg_rdata  output  32  combinational read of the register at cfg_addr.
REQ-010 SHALL have port: INT  output  1  registered interrupt request to the core.
REQ-011 SHALL have port: int_id  output  4  registered id: 0 = none, 1..8 = irq_src, 9 = timer.
REQ-012 SHALL have port: busy  output  1  high while in state SERVICE.

Function
REQ-013 SHALL pass each irq_src bit through a 2-flop synchronizer before any use.
REQ-014 SHALL use register map: 0 ENABLE[8:0] RW; 1 EDGE[7:0] RW (1 = rising-edge, 0 = level); 2 PENDING[8:0] RO, write-1-to-clear edge bits; 3 CLAIMED[3:0] RO; 4 MTIME RW; 5 MTIMECMP RW; 6-7 read 0, writes ignored.
REQ-015 SHALL set an edge source's pending bit on a synchronized 0->1 transition and hold it until claimed or W1C-cleared; simultaneous set and clear -> set wins.
REQ-016 SHALL make a level source's pending bit equal to its synchronized level, masked from arbitration while it is the claimed id.
REQ-017 SHALL arbitrate with fixed priority over enabled pending bits: lowest id wins; timer (id 9) lowest priority.
REQ-018 SHALL implement FSM IDLE, REQ, SERVICE; reset state IDLE.
REQ-019 IDLE->REQ when any enabled pending bit exists; INT=1 and int_id = winner in the same registered update.
REQ-020 In REQ, int_id SHALL re-arbitrate every cycle (a higher-priority arrival replaces it); REQ->IDLE if all enabled pending bits vanish before claim.
REQ-021 REQ->SERVICE on int_claim: CLAIMED <= int_id, INT <= 0, claimed edge pending bit cleared, busy <= 1.
REQ-022 SERVICE->IDLE on int_complete: CLAIMED <= 0, busy <= 0; no nesting, so new requests wait for IDLE.
REQ-023 SHALL ignore int_claim outside REQ and int_complete outside SERVICE; claim and complete together in SERVICE -> complete honored, claim ignored.
REQ-024 Latency: source rising at cycle N (setup met) -> INT=1 visible after edge N+3 (2 sync + pending + FSM).
REQ-025 Clearing an ENABLE bit SHALL remove that source from arbitration on the next cycle and SHALL NOT affect an already-claimed id.

Reset
REQ-026 On rst: state IDLE, INT=0, int_id=0, busy=0, ENABLE=0, EDGE=0, PENDING=0, CLAIMED=0, synchronizers=0, MTIME=0, MTIMECMP=0xFFFFFFFF.
REQ-027 rst asserted in any state SHALL abort service without requiring int_complete.

Configuration
REQ-028 Macro RV_INT_CTRL_TIMER_EN SHALL compile in the machine timer: MTIME increments every cycle, wraps 0xFFFFFFFF->0; a cfg write to MTIME takes priority over the increment; timer pending (bit 8) = MTIME >= MTIMECMP (unsigned), level type, cleared by writing MTIMECMP.
REQ-029 Without RV_INT_CTRL_TIMER_EN: no MTIME/MTIMECMP storage, addresses 4-5 read 0, PENDING[8] and ENABLE[8] tied 0, id 9 never issued.

Verification
REQ-030 ENABLE=0x001, EDGE=0x01, pulse irq_src[0] at cycle 10 -> INT=1, int_id=1 after edge 13; claim -> INT=0, CLAIMED=1, PENDING[0]=0; complete -> busy=0.
REQ-031 ENABLE=0x0FF, level irq_src[5] then irq_src[2] high before claim -> int_id 6 then 3; claim -> CLAIMED=3.
REQ-032 Level source held high through complete -> INT re-asserts one cycle after return to IDLE with same id.
REQ-033 Claim and complete pulsed together in SERVICE -> IDLE, CLAIMED=0; claim in IDLE -> no change.
REQ-034 TIMER_EN, ENABLE=0x100, MTIMECMP=20 after reset -> INT=1, int_id=9 once MTIME>=20; write MTIMECMP=0xFFFFFFFF -> pending clears.
REQ-035 rst during SERVICE -> all outputs 0 next cycle, CLAIMED=0, ENABLE=0.
